// File: rtl/icetap_spi_slave.sv
// icetap_spi_slave: SPI (mode 0) target front end for the icetap scan block.
//
// The SPI pins are oversampled in the scan_clk domain. The first byte of a
// transaction, sent MSB first, selects a scan chain. The remaining bits become
// shift-enable, shift-data and update strobes for that chain, and the chain's
// serial output is returned on spi_miso.
//
// Ports
//   scan_clk, scan_reset          clock, synchronous active-high reset
//   spi_sck, spi_cs_n, spi_mosi   asynchronous SPI inputs
//   spi_miso                      registered SPI data out
//   cmd_shift_*                   CMD chain (write, with update on CS release)
//   status_shift_*                STATUS chain (read, update before shifting)
//   store_mask_shift_*            STORE_MASK chain (write)
//   trigger_mask_shift_*          TRIGGER_MASK chain (write)
//   data_shift_*                  DATA chain (read, update before shifting)
//
// Address 0x00 shifts out a fixed 32-bit ID, LSB first, followed by zeros.
// Unknown addresses produce no strobes and keep spi_miso low.

module icetap_spi_slave (
    input  logic scan_clk,
    input  logic scan_reset,
    input  logic spi_sck,
    input  logic spi_cs_n,
    input  logic spi_mosi,
    output logic spi_miso,
    output logic cmd_shift_ena,
    output logic cmd_shift_data,
    output logic cmd_shift_update,
    output logic status_shift_update,
    output logic status_shift_ena,
    input  logic status_shift_data,
    output logic store_mask_shift_ena,
    output logic store_mask_shift_data,
    output logic trigger_mask_shift_ena,
    output logic trigger_mask_shift_data,
    output logic data_shift_update,
    output logic data_shift_ena,
    input  logic data_shift_data
);

    localparam logic [31:0] IdValue         = 32'h1CE7_A900;
    localparam logic [7:0]  AddrId          = 8'h00;
    localparam logic [7:0]  AddrCmd         = 8'h01;
    localparam logic [7:0]  AddrStatus      = 8'h02;
    localparam logic [7:0]  AddrStoreMask   = 8'h03;
    localparam logic [7:0]  AddrTriggerMask = 8'h04;
    localparam logic [7:0]  AddrData        = 8'h05;

    typedef enum logic [1:0] {StIdle, StAddr, StXfer, StWaitCs} state_e;

    // ------------------------------------------------------------------
    // Input conditioning: 2-FF synchronizers plus an edge-detect stage.
    // These carry no reset so that a mid-transfer reset still sees the
    // true pin levels on the very next cycle.
    // ------------------------------------------------------------------
    logic [1:0] sck_sync_q, cs_sync_q, mosi_sync_q;
    logic       sck_prev_q, cs_prev_q;

    always_ff @(posedge scan_clk) begin
        sck_sync_q  <= {sck_sync_q[0], spi_sck};
        cs_sync_q   <= {cs_sync_q[0], spi_cs_n};
        mosi_sync_q <= {mosi_sync_q[0], spi_mosi};
        sck_prev_q  <= sck_sync_q[1];
        cs_prev_q   <= cs_sync_q[1];
    end

    logic sck_s, cs_s, mosi_s;
    logic sck_rise, sck_fall, cs_rise, cs_fall;

    assign sck_s    = sck_sync_q[1];
    assign cs_s     = cs_sync_q[1];
    assign mosi_s   = mosi_sync_q[1];
    assign sck_rise = sck_s & ~sck_prev_q;
    assign sck_fall = ~sck_s & sck_prev_q;
    assign cs_rise  = cs_s & ~cs_prev_q;
    assign cs_fall  = ~cs_s & cs_prev_q;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_e      state_q, state_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [6:0]  addr_sr_q, addr_sr_d;
    logic [7:0]  addr_q, addr_d;
    logic [31:0] id_sr_q, id_sr_d;
    logic        mosi_q, mosi_d;
    logic        data_seen_q, data_seen_d;
    logic        miso_q, miso_d;

    logic cmd_ena_q, cmd_ena_d, cmd_upd_q, cmd_upd_d;
    logic sm_ena_q, sm_ena_d, tm_ena_q, tm_ena_d;
    logic st_ena_q, st_ena_d, st_upd_q, st_upd_d;
    logic dt_ena_q, dt_ena_d, dt_upd_q, dt_upd_d;

    logic [7:0] addr_new;
    assign addr_new = {addr_sr_q, mosi_s};

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        addr_sr_d   = addr_sr_q;
        addr_d      = addr_q;
        id_sr_d     = id_sr_q;
        mosi_d      = mosi_q;
        data_seen_d = data_seen_q;
        miso_d      = miso_q;
        cmd_ena_d   = 1'b0;
        cmd_upd_d   = 1'b0;
        sm_ena_d    = 1'b0;
        tm_ena_d    = 1'b0;
        st_ena_d    = 1'b0;
        st_upd_d    = 1'b0;
        dt_ena_d    = 1'b0;
        dt_upd_d    = 1'b0;

        unique case (state_q)
            StIdle: begin
                miso_d = 1'b0;
                if (cs_fall) begin
                    state_d     = StAddr;
                    bit_cnt_d   = '0;
                    addr_sr_d   = '0;
                    data_seen_d = 1'b0;
                end
            end

            StAddr: begin
                miso_d = 1'b0;
                if (cs_rise) begin
                    // Aborted address phase: nothing reaches the chains.
                    state_d = StIdle;
                end else if (sck_rise) begin
                    addr_sr_d = addr_new[6:0];
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        addr_d   = addr_new;
                        id_sr_d  = IdValue;
                        state_d  = StXfer;
                        // Read chains capture now, well before the 8th fall.
                        st_upd_d = (addr_new == AddrStatus);
                        dt_upd_d = (addr_new == AddrData);
                    end
                end
            end

            StXfer: begin
                if (cs_rise) begin
                    // CS release wins over any coincident SCK edge.
                    state_d   = StIdle;
                    miso_d    = 1'b0;
                    cmd_upd_d = (addr_q == AddrCmd) && data_seen_q;
                end else begin
                    if (sck_rise) begin
                        mosi_d = mosi_s;
                        case (addr_q)
                            AddrCmd: begin
                                cmd_ena_d   = 1'b1;
                                data_seen_d = 1'b1;
                            end
                            AddrStoreMask:   sm_ena_d = 1'b1;
                            AddrTriggerMask: tm_ena_d = 1'b1;
                            default: ;
                        endcase
                    end
                    if (sck_fall) begin
                        case (addr_q)
                            AddrId: begin
                                miso_d  = id_sr_q[0];
                                id_sr_d = {1'b0, id_sr_q[31:1]};
                            end
                            AddrStatus: begin
                                miso_d   = status_shift_data;
                                st_ena_d = 1'b1;
                            end
                            AddrData: begin
                                miso_d   = data_shift_data;
                                dt_ena_d = 1'b1;
                            end
                            default: miso_d = 1'b0;
                        endcase
                    end
                end
            end

            StWaitCs: begin
                miso_d = 1'b0;
                if (cs_s) begin
                    state_d = StIdle;
                end
            end

            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge scan_clk) begin
        if (scan_reset) begin
            // Coming out of reset with CS asserted means we joined a
            // transaction part-way; sit it out.
            state_q     <= cs_s ? StIdle : StWaitCs;
            bit_cnt_q   <= '0;
            addr_sr_q   <= '0;
            addr_q      <= '0;
            id_sr_q     <= '0;
            mosi_q      <= 1'b0;
            data_seen_q <= 1'b0;
            miso_q      <= 1'b0;
            cmd_ena_q   <= 1'b0;
            cmd_upd_q   <= 1'b0;
            sm_ena_q    <= 1'b0;
            tm_ena_q    <= 1'b0;
            st_ena_q    <= 1'b0;
            st_upd_q    <= 1'b0;
            dt_ena_q    <= 1'b0;
            dt_upd_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            addr_sr_q   <= addr_sr_d;
            addr_q      <= addr_d;
            id_sr_q     <= id_sr_d;
            mosi_q      <= mosi_d;
            data_seen_q <= data_seen_d;
            miso_q      <= miso_d;
            cmd_ena_q   <= cmd_ena_d;
            cmd_upd_q   <= cmd_upd_d;
            sm_ena_q    <= sm_ena_d;
            tm_ena_q    <= tm_ena_d;
            st_ena_q    <= st_ena_d;
            st_upd_q    <= st_upd_d;
            dt_ena_q    <= dt_ena_d;
            dt_upd_q    <= dt_upd_d;
        end
    end

    assign spi_miso                = miso_q;
    assign cmd_shift_ena           = cmd_ena_q;
    assign cmd_shift_update        = cmd_upd_q;
    assign store_mask_shift_ena    = sm_ena_q;
    assign trigger_mask_shift_ena  = tm_ena_q;
    assign status_shift_ena        = st_ena_q;
    assign status_shift_update     = st_upd_q;
    assign data_shift_ena          = dt_ena_q;
    assign data_shift_update       = dt_upd_q;
    // All write chains share one sampled MOSI bit.
    assign cmd_shift_data          = mosi_q;
    assign store_mask_shift_data   = mosi_q;
    assign trigger_mask_shift_data = mosi_q;

endmodule

// File: tb/tb_icetap_spi_slave.sv
module tb_icetap_spi_slave;

    localparam int Half = 6;

    logic scan_clk = 1'b0;
    logic scan_reset, spi_sck, spi_cs_n, spi_mosi;
    logic spi_miso;
    logic cmd_shift_ena, cmd_shift_data, cmd_shift_update;
    logic status_shift_update, status_shift_ena, status_shift_data;
    logic store_mask_shift_ena, store_mask_shift_data;
    logic trigger_mask_shift_ena, trigger_mask_shift_data;
    logic data_shift_update, data_shift_ena, data_shift_data;

    always #5 scan_clk = ~scan_clk;

    icetap_spi_slave dut (
        .scan_clk                (scan_clk),
        .scan_reset              (scan_reset),
        .spi_sck                 (spi_sck),
        .spi_cs_n                (spi_cs_n),
        .spi_mosi                (spi_mosi),
        .spi_miso                (spi_miso),
        .cmd_shift_ena           (cmd_shift_ena),
        .cmd_shift_data          (cmd_shift_data),
        .cmd_shift_update        (cmd_shift_update),
        .status_shift_update     (status_shift_update),
        .status_shift_ena        (status_shift_ena),
        .status_shift_data       (status_shift_data),
        .store_mask_shift_ena    (store_mask_shift_ena),
        .store_mask_shift_data   (store_mask_shift_data),
        .trigger_mask_shift_ena  (trigger_mask_shift_ena),
        .trigger_mask_shift_data (trigger_mask_shift_data),
        .data_shift_update       (data_shift_update),
        .data_shift_ena          (data_shift_ena),
        .data_shift_data         (data_shift_data)
    );

    // Read-chain devices: load on update, shift right on enable.
    logic [15:0] status_value = 16'h0;
    logic [15:0] data_value   = 16'h0;
    logic [15:0] status_chain = 16'h0;
    logic [15:0] data_chain   = 16'h0;

    always @(posedge scan_clk) begin
        if (status_shift_update)   status_chain <= status_value;
        else if (status_shift_ena) status_chain <= status_chain >> 1;
        if (data_shift_update)     data_chain <= data_value;
        else if (data_shift_ena)   data_chain <= data_chain >> 1;
    end
    assign status_shift_data = status_chain[0];
    assign data_shift_data   = data_chain[0];

    // Strobe monitor: 0 cmd_ena, 1 cmd_upd, 2 sm_ena, 3 tm_ena,
    // 4 status_upd, 5 status_ena, 6 data_upd, 7 data_ena.
    logic [7:0] strobes;
    assign strobes = {data_shift_ena, data_shift_update, status_shift_ena, status_shift_update,
                      trigger_mask_shift_ena, store_mask_shift_ena, cmd_shift_update,
                      cmd_shift_ena};

    int   cnt[8]     = '{default: 0};
    int   onehot_err = 0;
    logic wdata_q[$];

    always @(negedge scan_clk) begin
        for (int i = 0; i < 8; i++) if (strobes[i]) cnt[i] <= cnt[i] + 1;
        if ($countones(strobes) > 1) onehot_err <= onehot_err + 1;
        if (cmd_shift_ena)          wdata_q.push_back(cmd_shift_data);
        if (store_mask_shift_ena)   wdata_q.push_back(store_mask_shift_data);
        if (trigger_mask_shift_ena) wdata_q.push_back(trigger_mask_shift_data);
    end

    string names[8] = '{"cmd_ena", "cmd_upd", "sm_ena", "tm_ena",
                        "status_upd", "status_ena", "data_upd", "data_ena"};

    int          checks = 0;
    int          errors = 0;
    int          base_cnt[8];
    int          base_wq;
    int          base_onehot;
    int          exp_cnt[8];
    logic        miso_bits[$];
    logic        miso_idle;
    logic [31:0] id_word = 32'h1CE7_A900;

    task automatic wait_clks(input int n);
        repeat (n) @(posedge scan_clk);
        #1;
    endtask

    task automatic snap();
        for (int i = 0; i < 8; i++) base_cnt[i] = cnt[i];
        base_wq     = wdata_q.size();
        base_onehot = onehot_err;
    endtask

    // One SCK period; MISO is sampled at the end of the low phase.
    task automatic drive_bit(input logic b, input logic sample);
        spi_mosi = b;
        wait_clks(Half);
        if (sample) miso_bits.push_back(spi_miso);
        spi_sck = 1'b1;
        wait_clks(Half);
        spi_sck = 1'b0;
    endtask

    // nrise SCK cycles: address MSB first, then data bits LSB-index first.
    task automatic spi_xfer(input logic [7:0] addr, input int nrise, input logic [63:0] data);
        miso_bits.delete();
        spi_cs_n = 1'b0;
        wait_clks(Half);
        for (int k = 1; k <= nrise; k++) begin
            if (k <= 8) drive_bit(addr[8-k], 1'b0);
            else        drive_bit(data[k-9], 1'b1);
        end
        wait_clks(Half);
        if (nrise >= 8) miso_bits.push_back(spi_miso);
        spi_cs_n = 1'b1;
        spi_mosi = 1'b0;
        wait_clks(8);
        miso_idle = spi_miso;
    endtask

    // Expected strobe counts for a completed transaction of nrise SCK cycles.
    // Read chains shift once per falling edge from the 8th onward.
    task automatic model_counts(input logic [7:0] addr, input int nrise);
        int nd;
        nd = nrise - 8;
        for (int i = 0; i < 8; i++) exp_cnt[i] = 0;
        if (nd >= 0) begin
            case (addr)
                8'h01: begin exp_cnt[0] = nd; exp_cnt[1] = (nd > 0) ? 1 : 0; end
                8'h03: exp_cnt[2] = nd;
                8'h04: exp_cnt[3] = nd;
                8'h02: begin exp_cnt[4] = 1; exp_cnt[5] = nd + 1; end
                8'h05: begin exp_cnt[6] = 1; exp_cnt[7] = nd + 1; end
                default: ;
            endcase
        end
    endtask

    function automatic logic exp_miso(input logic [7:0] addr, input int j);
        case (addr)
            8'h00:   return (j < 32) ? id_word[j[4:0]] : 1'b0;
            8'h02:   return (j < 16) ? status_value[j[3:0]] : 1'b0;
            8'h05:   return (j < 16) ? data_value[j[3:0]] : 1'b0;
            default: return 1'b0;
        endcase
    endfunction

    function automatic int exp_nmiso(input int nrise);
        return (nrise >= 8) ? nrise - 7 : 0;
    endfunction

    task automatic test_reset();
        logic [11:0] outs;
        scan_reset = 1'b1;
        spi_cs_n   = 1'b1;
        spi_sck    = 1'b0;
        spi_mosi   = 1'b0;
        wait_clks(6);
        scan_reset = 1'b0;
        wait_clks(1);
        outs = {spi_miso, cmd_shift_ena, cmd_shift_data, cmd_shift_update, status_shift_update,
                status_shift_ena, store_mask_shift_ena, store_mask_shift_data,
                trigger_mask_shift_ena, trigger_mask_shift_data, data_shift_update,
                data_shift_ena};
        checks++;
        if (outs !== 12'h000) begin
            errors++;
            $display("FAIL reset_outputs: got %b expected 000000000000", outs);
        end
    endtask

    task automatic test_cmd_write();
        logic [63:0] d;
        d = 64'b101;
        snap();
        spi_xfer(8'h01, 11, d);
        model_counts(8'h01, 11);
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (cnt[i] - base_cnt[i] !== exp_cnt[i]) begin
                errors++;
                $display("FAIL cmd_write %s: got %0d expected %0d", names[i],
                         cnt[i] - base_cnt[i], exp_cnt[i]);
            end
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (wdata_q.size() <= base_wq + i || wdata_q[base_wq+i] !== d[i]) begin
                errors++;
                $display("FAIL cmd_write data[%0d]: got %b expected %b", i,
                         (wdata_q.size() > base_wq + i) ? wdata_q[base_wq+i] : 1'bx, d[i]);
            end
        end
    endtask

    task automatic test_status_read();
        status_value = 16'h00A5;
        snap();
        spi_xfer(8'h02, 15, 64'h0);
        model_counts(8'h02, 15);
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (cnt[i] - base_cnt[i] !== exp_cnt[i]) begin
                errors++;
                $display("FAIL status_read %s: got %0d expected %0d", names[i],
                         cnt[i] - base_cnt[i], exp_cnt[i]);
            end
        end
        checks++;
        if (miso_bits.size() != 8) begin
            errors++;
            $display("FAIL status_read miso_count: got %0d expected 8", miso_bits.size());
        end else begin
            for (int j = 0; j < 8; j++) begin
                checks++;
                if (miso_bits[j] !== exp_miso(8'h02, j)) begin
                    errors++;
                    $display("FAIL status_read miso[%0d]: got %b expected %b", j,
                             miso_bits[j], exp_miso(8'h02, j));
                end
            end
        end
    endtask

    task automatic test_id_read();
        logic [31:0] got;
        int          zeros;
        snap();
        spi_xfer(8'h00, 47, 64'h0);
        model_counts(8'h00, 47);
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (cnt[i] - base_cnt[i] !== exp_cnt[i]) begin
                errors++;
                $display("FAIL id_read %s: got %0d expected %0d", names[i],
                         cnt[i] - base_cnt[i], exp_cnt[i]);
            end
        end
        checks++;
        if (miso_bits.size() != exp_nmiso(47)) begin
            errors++;
            $display("FAIL id_read miso_count: got %0d expected %0d", miso_bits.size(),
                     exp_nmiso(47));
        end else begin
            got   = '0;
            zeros = 0;
            for (int j = 0; j < 32; j++) got[j] = miso_bits[j];
            for (int j = 32; j < 40; j++) if (miso_bits[j] === 1'b0) zeros++;
            checks++;
            if (got !== id_word) begin
                errors++;
                $display("FAIL id_read word: got %h expected %h", got, id_word);
            end
            checks++;
            if (zeros != 8) begin
                errors++;
                $display("FAIL id_read trailing_zeros: got %0d expected 8", zeros);
            end
        end
    endtask

    task automatic test_abort();
        logic [63:0] d;
        snap();
        spi_xfer(8'h03, 5, 64'h0);
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (cnt[i] != base_cnt[i]) begin
                errors++;
                $display("FAIL abort %s: got %0d expected 0", names[i], cnt[i] - base_cnt[i]);
            end
        end
        d = {$urandom, $urandom};
        snap();
        spi_xfer(8'h03, 56, d);
        checks++;
        if (cnt[2] - base_cnt[2] != 48) begin
            errors++;
            $display("FAIL after_abort sm_ena: got %0d expected 48", cnt[2] - base_cnt[2]);
        end
        for (int i = 0; i < 48; i++) begin
            if (wdata_q.size() > base_wq + i && wdata_q[base_wq+i] !== d[i]) begin
                errors++;
                $display("FAIL after_abort data[%0d]: got %b expected %b", i,
                         wdata_q[base_wq+i], d[i]);
            end
            checks++;
        end
    endtask

    task automatic test_unknown_addr();
        int ones;
        snap();
        spi_xfer(8'h07, 24, {$urandom, $urandom});
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (cnt[i] != base_cnt[i]) begin
                errors++;
                $display("FAIL unknown %s: got %0d expected 0", names[i], cnt[i] - base_cnt[i]);
            end
        end
        ones = 0;
        foreach (miso_bits[j]) if (miso_bits[j] !== 1'b0) ones++;
        checks++;
        if (ones != 0 || miso_bits.size() != exp_nmiso(24)) begin
            errors++;
            $display("FAIL unknown miso: got %0d nonzero of %0d expected 0 of %0d", ones,
                     miso_bits.size(), exp_nmiso(24));
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] outs;
        snap();
        spi_cs_n = 1'b0;
        wait_clks(Half);
        for (int k = 7; k >= 0; k--) drive_bit(k == 0, 1'b0);
        drive_bit(1'b1, 1'b0);
        drive_bit(1'b1, 1'b0);
        wait_clks(Half);
        scan_reset = 1'b1;
        wait_clks(1);
        scan_reset = 1'b0;
        outs = strobes;
        checks++;
        if (outs !== 8'h00 || spi_miso !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid outputs: got strobes %b miso %b expected 0", outs, spi_miso);
        end
        for (int k = 0; k < 6; k++) drive_bit(1'b1, 1'b0);
        wait_clks(Half);
        spi_cs_n = 1'b1;
        wait_clks(8);
        checks++;
        if (cnt[0] - base_cnt[0] != 2) begin
            errors++;
            $display("FAIL reset_mid cmd_ena: got %0d expected 2", cnt[0] - base_cnt[0]);
        end
        checks++;
        if (cnt[1] != base_cnt[1]) begin
            errors++;
            $display("FAIL reset_mid cmd_upd: got %0d expected 0", cnt[1] - base_cnt[1]);
        end
        snap();
        spi_xfer(8'h04, 18, 64'h3FF);
        checks++;
        if (cnt[3] - base_cnt[3] != 10) begin
            errors++;
            $display("FAIL reset_mid follow tm_ena: got %0d expected 10", cnt[3] - base_cnt[3]);
        end
    endtask

    task automatic test_random();
        logic [7:0]  addr;
        logic [63:0] d;
        int          nd, nrise, nw;
        for (int t = 0; t < 14; t++) begin
            addr         = ($urandom_range(0, 7) == 7) ? 8'($urandom) : 8'($urandom_range(0, 6));
            nd           = $urandom_range(0, 40);
            nrise        = 8 + nd;
            d            = {$urandom, $urandom};
            status_value = 16'($urandom);
            data_value   = 16'($urandom);
            snap();
            spi_xfer(addr, nrise, d);
            model_counts(addr, nrise);
            for (int i = 0; i < 8; i++) begin
                checks++;
                if (cnt[i] - base_cnt[i] !== exp_cnt[i]) begin
                    errors++;
                    $display("FAIL random[%0d] addr %h %s: got %0d expected %0d", t, addr,
                             names[i], cnt[i] - base_cnt[i], exp_cnt[i]);
                end
            end
            nw = (addr == 8'h01 || addr == 8'h03 || addr == 8'h04) ? nd : 0;
            checks++;
            if (wdata_q.size() - base_wq != nw) begin
                errors++;
                $display("FAIL random[%0d] wdata_count: got %0d expected %0d", t,
                         wdata_q.size() - base_wq, nw);
            end else begin
                for (int i = 0; i < nw; i++) begin
                    checks++;
                    if (wdata_q[base_wq+i] !== d[i]) begin
                        errors++;
                        $display("FAIL random[%0d] wdata[%0d]: got %b expected %b", t, i,
                                 wdata_q[base_wq+i], d[i]);
                    end
                end
            end
            checks++;
            if (miso_bits.size() != exp_nmiso(nrise)) begin
                errors++;
                $display("FAIL random[%0d] miso_count: got %0d expected %0d", t,
                         miso_bits.size(), exp_nmiso(nrise));
            end else begin
                for (int j = 0; j < miso_bits.size(); j++) begin
                    checks++;
                    if (miso_bits[j] !== exp_miso(addr, j)) begin
                        errors++;
                        $display("FAIL random[%0d] addr %h miso[%0d]: got %b expected %b", t,
                                 addr, j, miso_bits[j], exp_miso(addr, j));
                    end
                end
            end
            checks++;
            if (miso_idle !== 1'b0) begin
                errors++;
                $display("FAIL random[%0d] miso_idle: got %b expected 0", t, miso_idle);
            end
            checks++;
            if (onehot_err != base_onehot) begin
                errors++;
                $display("FAIL random[%0d] onehot: got %0d overlaps expected 0", t,
                         onehot_err - base_onehot);
            end
        end
    endtask

    initial begin
        test_reset();
        test_cmd_write();
        test_status_read();
        test_id_read();
        test_abort();
        test_unknown_addr();
        test_reset_mid();
        test_random();
        checks++;
        if (onehot_err != 0) begin
            errors++;
            $display("FAIL onehot_total: got %0d overlaps expected 0", onehot_err);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
